mul_div_unit: RTL

Parametrised, multi-cycle HI/LO multiply/divide unit for the MIPS pipelined CPU, the sequential successor to the single-cycle combinational ALU. It sits in the EX stage beside the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO results are held in internal architectural registers. A busy handshake stalls the pipeline while an iterative operation runs, and a flush input squashes an in-flight operation.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_step.sv | 38 +++
 rtl/mul_div_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM states.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath on unsigned magnitudes.
// Multiply: {hi,lo} holds {partial, multiplier}; add b if lo[0], shift right.
// Divide:   {hi,lo} holds {remainder, dividend}; shift left, trial-subtract b.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Single shift-add or restoring-divide step; remainder < b keeps trial within WIDTH+1 bits.
  always_comb begin
    sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b} : '0);
    trial = {hi_in, lo_in[WIDTH-1]};
    diff  = trial - {1'b0, b};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = trial[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage. One bit per cycle,
// WIDTH cycles per MULT*/DIV*, single-cycle MTHI/MTLO, flush squashes in-flight work.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] w_hi, w_lo, b_reg;
  logic             is_div, neg_q, neg_r, dz;

  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] s_hi, s_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand sign/magnitude split and final sign fix-up of the last step's result.
  always_comb begin
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    a_neg     = op_signed & rs[WIDTH-1];
    b_neg     = op_signed & rt[WIDTH-1];
    rs_mag    = a_neg ? -rs : rs;
    rt_mag    = b_neg ? -rt : rt;
    prod_fix  = neg_q ? -{s_hi, s_lo} : {s_hi, s_lo};
    // Divide by zero leaves |rs| in the remainder, so the remainder fix-up restores rs.
    quot_fix  = dz ? '1 : (neg_q ? -s_lo : s_lo);
    rem_fix   = neg_r ? -s_hi : s_hi;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .hi_in    (w_hi),
    .lo_in    (w_lo),
    .b        (b_reg),
    .hi_out   (s_hi),
    .lo_out   (s_lo)
  );

  // Control FSM, iteration registers and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MDU_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (start && !flush) begin
            case (op)
              MDU_MTHI: hi <= rs;
              MDU_MTLO: lo <= rs;
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                state  <= MDU_RUN;
                busy   <= 1'b1;
                cnt    <= CW'(WIDTH);
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= (rt == '0);
                w_hi   <= '0;
                w_lo   <= op[1] ? rs_mag : rt_mag;
                b_reg  <= op[1] ? rt_mag : rs_mag;
              end
              default: ;
            endcase
          end
        end
        MDU_RUN: begin
          if (flush) begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
          end else if (cnt == CW'(1)) begin
            state <= MDU_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end else begin
            w_hi <= s_hi;
            w_lo <= s_lo;
            cnt  <= cnt - CW'(1);
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule
